flash_arbiter: RTL and testbench

Shares the single asynchronous-read NOR flash port between two read requesters: the cartridge ROM path (CPU side) and a loader path (bulk copy of ROM/boot images into BRAM). Runs a timed read sequence per access: drive address, wait a fixed number of cycles for flash access time, capture the data, then recover. Sits between `cartridge_sim`/loader logic and the board flash pins. The cartridge path no longer drives the flash pins directly.

---
 rtl/flash_arbiter.sv | 146 ++++++++++++++
 tb/tb_flash_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read NOR flash port between the
// cartridge read path and the loader path, with a fixed-length timed read per access.
module flash_arbiter #(
  parameter int P_WAIT_CYCLES = 4,
  parameter int P_ADDR_W      = 24
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic                I_CART_REQ,
  input  logic [P_ADDR_W-1:0] I_CART_ADDR,
  output logic                O_CART_ACK,
  output logic [15:0]         O_CART_DATA,
  input  logic                I_LOAD_REQ,
  input  logic [P_ADDR_W-1:0] I_LOAD_ADDR,
  output logic                O_LOAD_ACK,
  output logic [15:0]         O_LOAD_DATA,
  output logic [P_ADDR_W-1:0] O_FLASH_ADDR,
  input  logic [15:0]         I_FLASH_DATA,
  output logic                O_FLASH_CE_L,
  output logic                O_FLASH_OE_L,
  output logic                O_ADDR_VALID_L,
  output logic                O_FLASH_WE_L,
  output logic                O_FLASH_CLK,
  output logic                O_BUSY,
  output logic                O_GRANT
);

  localparam logic [7:0] L_LAST = 8'(P_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_cnt;
  logic                r_last_grant;
  logic                r_grant;
  logic                r_busy;
  logic                r_strobe_l;
  logic                r_cart_ack;
  logic                r_load_ack;
  logic [15:0]         r_cart_data;
  logic [15:0]         r_load_data;
  logic [P_ADDR_W-1:0] r_flash_addr;
  logic                w_pick;
  logic                w_start;
  logic                w_done;

  // On a tie the requester that was not served last wins (1 = loader).
  always_comb begin
    w_pick  = 1'b0;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_next  = r_state;
    if (I_CART_REQ && I_LOAD_REQ) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = I_LOAD_REQ;
    end
    case (r_state)
      S_IDLE: begin
        if (I_CART_REQ || I_LOAD_REQ) begin
          w_start = 1'b1;
          w_next  = S_ACCESS;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (r_cnt == L_LAST) begin
          w_done = 1'b1;
          w_next = S_RECOVER;
        end else begin
          w_next = S_ACCESS;
        end
      end
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Strobes and busy are registered from the next state so they line up with it.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_cnt        <= 8'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_busy       <= 1'b0;
      r_strobe_l   <= 1'b1;
      r_cart_ack   <= 1'b0;
      r_load_ack   <= 1'b0;
      r_cart_data  <= 16'd0;
      r_load_data  <= 16'd0;
      r_flash_addr <= '0;
    end else begin
      r_cart_ack <= 1'b0;
      r_load_ack <= 1'b0;
      r_strobe_l <= (w_next != S_ACCESS);
      r_busy     <= (w_next != S_IDLE);
      if (w_start) begin
        r_flash_addr <= w_pick ? I_LOAD_ADDR : I_CART_ADDR;
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_cnt        <= 8'd0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_done) begin
        if (r_grant) begin
          r_load_data <= I_FLASH_DATA;
          r_load_ack  <= 1'b1;
        end else begin
          r_cart_data <= I_FLASH_DATA;
          r_cart_ack  <= 1'b1;
        end
      end
    end
  end

  assign O_CART_ACK     = r_cart_ack;
  assign O_CART_DATA    = r_cart_data;
  assign O_LOAD_ACK     = r_load_ack;
  assign O_LOAD_DATA    = r_load_data;
  assign O_FLASH_ADDR   = r_flash_addr;
  assign O_FLASH_CE_L   = r_strobe_l;
  assign O_FLASH_OE_L   = r_strobe_l;
  assign O_ADDR_VALID_L = r_strobe_l;
  assign O_FLASH_WE_L   = 1'b1;
  assign O_FLASH_CLK    = 1'b1;
  assign O_BUSY         = r_busy;
  assign O_GRANT        = r_grant;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: behavioural flash model plus per-scenario tasks.
module tb_flash_arbiter;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cart_req, load_req;
  logic [23:0] cart_addr, load_addr;
  logic        cart_ack, load_ack;
  logic [15:0] cart_data, load_data;
  logic [23:0] flash_addr;
  logic [15:0] flash_data;
  logic        ce_l, oe_l, avl_l, we_l, fclk, busy, grant;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ce_low_cnt;
  int ack_cyc_q[$];
  logic ack_who_q[$];
  logic [15:0] ack_data_q[$];

  function automatic logic [15:0] flash_model(logic [23:0] a);
    if (a == 24'h000150) return 16'hA5C3;
    return a[15:0] * 16'd3 + 16'h1234;
  endfunction

  assign flash_data = flash_model(flash_addr);

  flash_arbiter #(.P_WAIT_CYCLES(W), .P_ADDR_W(24)) dut (
    .I_CLK(clk), .I_RESET(rst),
    .I_CART_REQ(cart_req), .I_CART_ADDR(cart_addr), .O_CART_ACK(cart_ack), .O_CART_DATA(cart_data),
    .I_LOAD_REQ(load_req), .I_LOAD_ADDR(load_addr), .O_LOAD_ACK(load_ack), .O_LOAD_DATA(load_data),
    .O_FLASH_ADDR(flash_addr), .I_FLASH_DATA(flash_data),
    .O_FLASH_CE_L(ce_l), .O_FLASH_OE_L(oe_l), .O_ADDR_VALID_L(avl_l),
    .O_FLASH_WE_L(we_l), .O_FLASH_CLK(fclk), .O_BUSY(busy), .O_GRANT(grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge: ack owner, data and edge index.
  always @(negedge clk) begin
    if (!ce_l) ce_low_cnt++;
    if (cart_ack) begin
      ack_cyc_q.push_back(cyc); ack_who_q.push_back(1'b0); ack_data_q.push_back(cart_data);
    end
    if (load_ack) begin
      ack_cyc_q.push_back(cyc); ack_who_q.push_back(1'b1); ack_data_q.push_back(load_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    ack_cyc_q.delete();
    ack_who_q.delete();
    ack_data_q.delete();
    ce_low_cnt = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; cart_req = 1'b0; load_req = 1'b0; cart_addr = 24'h0; load_addr = 24'h0;
    #3;
    checks++;
    if ({ce_l, oe_l, avl_l, we_l, fclk} !== 5'b11111) begin
      failures++; $display("FAIL reset_strobes got=%b exp=11111", {ce_l, oe_l, avl_l, we_l, fclk});
    end
    checks++;
    if ({busy, grant, cart_ack, load_ack} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, grant, cart_ack, load_ack});
    end
    checks++;
    if ({flash_addr, cart_data, load_data} !== 56'h0) begin
      failures++; $display("FAIL reset_regs got=%h exp=0", {flash_addr, cart_data, load_data});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int e0;
    bit done;
    clear_log;
    done = 1'b0;
    cart_addr = 24'h000150; cart_req = 1'b1; e0 = cyc + 1;
    tick;
    checks++;
    if ({flash_addr, grant, busy, ce_l, oe_l} !== {24'h000150, 4'b0100}) begin
      failures++; $display("FAIL single_grant got=%h/%b%b%b%b exp=000150/0100", flash_addr, grant, busy, ce_l, oe_l);
    end
    for (int i = 0; i < 20 && !done; i++) begin
      tick;
      if (cart_ack) begin done = 1'b1; cart_req = 1'b0; end
    end
    repeat (4) tick;
    checks++;
    if (!done) begin failures++; $display("FAIL single_timeout got=no_ack exp=ack"); end
    checks++;
    if (ack_cyc_q.size() !== 1) begin
      failures++; $display("FAIL single_ack_count got=%0d exp=1", ack_cyc_q.size());
    end else begin
      checks++;
      if ({ack_who_q[0], ack_data_q[0]} !== {1'b0, 16'hA5C3} || ack_cyc_q[0] !== e0 + W) begin
        failures++; $display("FAIL single_ack got=who%0d data=%h cyc=%0d exp=who0 data=a5c3 cyc=%0d",
                             ack_who_q[0], ack_data_q[0], ack_cyc_q[0], e0 + W);
      end
    end
    checks++;
    if (ce_low_cnt !== W) begin failures++; $display("FAIL single_ce_cycles got=%0d exp=%0d", ce_low_cnt, W); end
    checks++;
    if ({cart_data, busy} !== {16'hA5C3, 1'b0}) begin
      failures++; $display("FAIL single_hold got=%h/%b exp=a5c3/0", cart_data, busy);
    end
  endtask

  task automatic test_simultaneous;
    int e0;
    bit cd, ld;
    do_reset;
    clear_log;
    cd = 1'b0; ld = 1'b0;
    cart_addr = 24'h10; load_addr = 24'h20; cart_req = 1'b1; load_req = 1'b1; e0 = cyc + 1;
    tick;
    checks++;
    if ({grant, flash_addr} !== {1'b0, 24'h10}) begin
      failures++; $display("FAIL tie_first_grant got=%b/%h exp=0/000010", grant, flash_addr);
    end
    for (int i = 0; i < 40 && !(cd && ld); i++) begin
      tick;
      if (cart_ack) begin cd = 1'b1; cart_req = 1'b0; end
      if (load_ack) begin ld = 1'b1; load_req = 1'b0; end
    end
    repeat (3) tick;
    checks++;
    if (ack_cyc_q.size() !== 2) begin
      failures++; $display("FAIL tie_ack_count got=%0d exp=2", ack_cyc_q.size());
    end else begin
      checks++;
      if ({ack_who_q[0], ack_data_q[0]} !== {1'b0, flash_model(24'h10)} || ack_cyc_q[0] !== e0 + W) begin
        failures++; $display("FAIL tie_cart_ack got=who%0d %h cyc=%0d exp=who0 %h cyc=%0d",
                             ack_who_q[0], ack_data_q[0], ack_cyc_q[0], flash_model(24'h10), e0 + W);
      end
      checks++;
      if ({ack_who_q[1], ack_data_q[1]} !== {1'b1, flash_model(24'h20)} || ack_cyc_q[1] - ack_cyc_q[0] !== W + 2) begin
        failures++; $display("FAIL tie_load_ack got=who%0d %h gap=%0d exp=who1 %h gap=%0d",
                             ack_who_q[1], ack_data_q[1], ack_cyc_q[1] - ack_cyc_q[0], flash_model(24'h20), W + 2);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int bad;
    clear_log;
    n = 0; bad = 0;
    cart_addr = 24'h100; load_addr = 24'h200; cart_req = 1'b1; load_req = 1'b1;
    for (int i = 0; i < 100 && n < 6; i++) begin
      tick;
      if (cart_ack) begin
        checks++;
        if (cart_data !== flash_model(cart_addr)) begin
          failures++; $display("FAIL b2b_cart_data got=%h exp=%h", cart_data, flash_model(cart_addr));
        end
        cart_addr = cart_addr + 24'd1; n++;
      end
      if (load_ack) begin
        checks++;
        if (load_data !== flash_model(load_addr)) begin
          failures++; $display("FAIL b2b_load_data got=%h exp=%h", load_data, flash_model(load_addr));
        end
        load_addr = load_addr + 24'd1; n++;
      end
    end
    cart_req = 1'b0; load_req = 1'b0;
    repeat (6) tick;
    checks++;
    if (ack_cyc_q.size() !== 6) begin
      failures++; $display("FAIL b2b_ack_count got=%0d exp=6", ack_cyc_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (ack_who_q[k] !== k[0]) bad++;
        if (k > 0 && ack_cyc_q[k] - ack_cyc_q[k-1] !== W + 2) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL b2b_alternation got=%0d_errors exp=0", bad); end
    end
  endtask

  task automatic test_reset_mid;
    bit done;
    clear_log;
    done = 1'b0;
    cart_addr = 24'h30; load_addr = 24'h31; cart_req = 1'b1; load_req = 1'b1;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ce_l, oe_l, avl_l, busy, grant, cart_ack, load_ack} !== 7'b1110000) begin
      failures++; $display("FAIL midreset_ctrl got=%b exp=1110000", {ce_l, oe_l, avl_l, busy, grant, cart_ack, load_ack});
    end
    checks++;
    if ({flash_addr, cart_data, load_data} !== 56'h0) begin
      failures++; $display("FAIL midreset_regs got=%h exp=0", {flash_addr, cart_data, load_data});
    end
    cart_req = 1'b0; load_req = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (ack_cyc_q.size() !== 0) begin failures++; $display("FAIL midreset_no_ack got=%0d exp=0", ack_cyc_q.size()); end
    cart_req = 1'b1; load_req = 1'b1;
    tick;
    checks++;
    if ({grant, flash_addr} !== {1'b0, 24'h30}) begin
      failures++; $display("FAIL midreset_tie got=%b/%h exp=0/000030", grant, flash_addr);
    end
    load_req = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick;
      if (cart_ack) begin done = 1'b1; cart_req = 1'b0; end
    end
    checks++;
    if (!done || cart_data !== flash_model(24'h30)) begin
      failures++; $display("FAIL midreset_read got=%b/%h exp=1/%h", done, cart_data, flash_model(24'h30));
    end
    repeat (2) tick;
  endtask

  task automatic test_withdrawn;
    clear_log;
    load_addr = 24'h77; load_req = 1'b1;
    tick;
    load_req = 1'b0;
    repeat (15) tick;
    checks++;
    if (ack_cyc_q.size() !== 1) begin
      failures++; $display("FAIL withdrawn_ack_count got=%0d exp=1", ack_cyc_q.size());
    end else begin
      checks++;
      if ({ack_who_q[0], ack_data_q[0]} !== {1'b1, flash_model(24'h77)}) begin
        failures++; $display("FAIL withdrawn_ack got=who%0d %h exp=who1 %h", ack_who_q[0], ack_data_q[0], flash_model(24'h77));
      end
    end
    checks++;
    if (ce_low_cnt !== W || busy !== 1'b0) begin
      failures++; $display("FAIL withdrawn_single_access got=%0d/%b exp=%0d/0", ce_low_cnt, busy, W);
    end
  endtask

  task automatic test_addr_change;
    int bad;
    bit done;
    clear_log;
    bad = 0; done = 1'b0;
    cart_addr = 24'h40; cart_req = 1'b1;
    tick;
    cart_addr = 24'h80;
    for (int i = 0; i < 20 && !done; i++) begin
      if (flash_addr !== 24'h40) bad++;
      tick;
      if (cart_ack) begin done = 1'b1; cart_req = 1'b0; end
    end
    checks++;
    if (bad !== 0 || flash_addr !== 24'h40) begin
      failures++; $display("FAIL addrchg_addr got=%h/%0d exp=000040/0", flash_addr, bad);
    end
    checks++;
    if (!done || cart_data !== flash_model(24'h40)) begin
      failures++; $display("FAIL addrchg_data got=%b/%h exp=1/%h", done, cart_data, flash_model(24'h40));
    end
    repeat (3) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_back_to_back;
    test_reset_mid;
    test_withdrawn;
    test_addr_change;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
